// File: rtl/skel_pkg.sv
// Shared types and helpers for the skeleton feature extractor.
package skel_pkg;

  localparam int COUNT_WIDTH = 16;

  typedef enum logic {
    PT_END    = 1'b0,
    PT_BRANCH = 1'b1
  } point_type_t;

  // Neighbour vector layout: p[0]=P2 (north), then clockwise to p[7]=P9 (north-west).
  function automatic logic [3:0] neighbour_count(input logic [7:0] p);
    return 4'($countones(p));
  endfunction

  // 0->1 transitions around the ring P2->P3 ... P9->P2.
  function automatic logic [3:0] crossing_number(input logic [7:0] p);
    logic [7:0] succ;
    succ = {p[0], p[7:1]};
    return 4'($countones(~p & succ));
  endfunction

endpackage

// File: rtl/skeleton_feature_extractor_fifo.sv
// First-word fall-through synchronous FIFO; head word is visible whenever not empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Status flags and accepted-operation qualifiers; a push into a full FIFO
  // is accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr[AW-1:0]];
  end

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Read and write pointers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/skeleton_feature_extractor.sv
// Classifies interior skeleton pixels as endpoints or branch points from a
// 3x3 window over the raster stream, queues records and keeps frame counts.
module skeleton_feature_extractor
  import skel_pkg::*;
#(
  parameter  int HORIZONTAL_COUNT = 320,
  parameter  int VERTICAL_COUNT   = 180,
  parameter  int FIFO_DEPTH       = 64,
  localparam int HWIDTH           = $clog2(HORIZONTAL_COUNT),
  localparam int VWIDTH           = $clog2(VERTICAL_COUNT)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   pixel_in,
  input  logic [HWIDTH-1:0]      hcount_in,
  input  logic [VWIDTH-1:0]      vcount_in,
  input  logic                   pixel_valid_in,
  output logic                   point_valid_out,
  input  logic                   point_ready_in,
  output logic                   point_type_out,
  output logic [HWIDTH-1:0]      point_h_out,
  output logic [VWIDTH-1:0]      point_v_out,
  output logic [COUNT_WIDTH-1:0] endpoint_count,
  output logic [COUNT_WIDTH-1:0] branch_count,
  output logic                   frame_done,
  output logic                   overflow
);

  // Record layout depends on the frame parameters, so it lives here rather than in the package.
  typedef struct packed {
    point_type_t       t;
    logic [HWIDTH-1:0] h;
    logic [VWIDTH-1:0] v;
  } point_t;

  localparam int PW = $bits(point_t);

  logic [HORIZONTAL_COUNT-1:0] line1, line2;   // rows v-1 and v-2
  logic [2:0]                  win_top, win_mid, win_bot;  // bit 0 = newest column
  logic [2:0]                  nxt_top, nxt_mid, nxt_bot;
  logic                        frame_start, frame_last, trigger;
  logic [7:0]                  nbr;
  logic                        is_end, is_branch;

  point_t                      cls_rec;
  logic                        cls_valid;
  logic                        end_d1;
  logic [COUNT_WIDTH-1:0]      run_end, run_branch;

  logic                        fifo_full, fifo_empty, fifo_pop;
  logic [PW-1:0]               head_bits;
  point_t                      head;

  // Window as it will look once the current pixel is shifted in; centre is (h-1, v-1).
  always_comb begin
    frame_start = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
    frame_last  = pixel_valid_in && (hcount_in == HWIDTH'(HORIZONTAL_COUNT - 1))
                                 && (vcount_in == VWIDTH'(VERTICAL_COUNT - 1));
    trigger     = pixel_valid_in && (hcount_in >= HWIDTH'(2)) && (vcount_in >= VWIDTH'(2));
    nxt_top     = {(frame_start ? 2'b00 : win_top[1:0]), line2[hcount_in]};
    nxt_mid     = {(frame_start ? 2'b00 : win_mid[1:0]), line1[hcount_in]};
    nxt_bot     = {(frame_start ? 2'b00 : win_bot[1:0]), pixel_in};
    nbr         = {nxt_top[2], nxt_mid[2], nxt_bot[2], nxt_bot[1],
                   nxt_bot[0], nxt_mid[0], nxt_top[0], nxt_top[1]};
    is_end      = trigger && nxt_mid[1] && (neighbour_count(nbr) == 4'd1);
    is_branch   = trigger && nxt_mid[1] && !is_end && (crossing_number(nbr) >= 4'd3);
  end

  // Line buffers and window shift registers advance only on accepted pixels.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      line1   <= '0;
      line2   <= '0;
      win_top <= '0;
      win_mid <= '0;
      win_bot <= '0;
    end else if (pixel_valid_in) begin
      line1[hcount_in] <= pixel_in;
      line2[hcount_in] <= line1[hcount_in];
      win_top          <= nxt_top;
      win_mid          <= nxt_mid;
      win_bot          <= nxt_bot;
    end
  end

  // Classification stage: one record register feeding the FIFO next cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cls_valid <= 1'b0;
      cls_rec   <= '0;
      end_d1    <= 1'b0;
    end else begin
      cls_valid <= is_end || is_branch;
      cls_rec.t <= is_branch ? PT_BRANCH : PT_END;
      cls_rec.h <= hcount_in - HWIDTH'(1);
      cls_rec.v <= vcount_in - VWIDTH'(1);
      end_d1    <= frame_last;
    end
  end

  // Running counts; the final classification lands together with end_d1,
  // so publishing one cycle later includes it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      run_end        <= '0;
      run_branch     <= '0;
      endpoint_count <= '0;
      branch_count   <= '0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= end_d1;
      if (end_d1) begin
        endpoint_count <= run_end;
        branch_count   <= run_branch;
        run_end        <= '0;
        run_branch     <= '0;
      end else begin
        if (is_end && (run_end != '1))       run_end    <= run_end + COUNT_WIDTH'(1);
        if (is_branch && (run_branch != '1)) run_branch <= run_branch + COUNT_WIDTH'(1);
      end
    end
  end

  // Sticky drop flag; a drop on the same cycle as a frame start still registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overflow <= 1'b0;
    end else if (cls_valid && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (frame_start) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (cls_valid),
    .wdata    (cls_rec),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .rdata    (head_bits),
    .empty    (fifo_empty)
  );

  // Head record presentation; fields read as zero while nothing is queued.
  always_comb begin
    head            = point_t'(head_bits);
    point_valid_out = !fifo_empty;
    fifo_pop        = point_valid_out && point_ready_in;
    point_type_out  = point_valid_out && (head.t == PT_BRANCH);
    point_h_out     = point_valid_out ? head.h : '0;
    point_v_out     = point_valid_out ? head.v : '0;
  end

endmodule

// File: tb/tb_skeleton_feature_extractor.sv
// Directed scoreboard bench: stimulus pushes expected records/counts, a
// monitor pops and compares on every handshake and frame_done pulse.
// Frame is 8x7 so the plus shape with length-2 arms fits inside the interior.
module tb_skeleton_feature_extractor;
  import skel_pkg::*;

  localparam int H  = 8;
  localparam int V  = 7;
  localparam int D  = 4;
  localparam int HW = 3;
  localparam int VW = 3;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          pixel_in = 1'b0;
  logic [HW-1:0] hcount_in = '0;
  logic [VW-1:0] vcount_in = '0;
  logic          pixel_valid_in = 1'b0;
  logic          point_valid_out;
  logic          point_ready_in = 1'b0;
  logic          point_type_out;
  logic [HW-1:0] point_h_out;
  logic [VW-1:0] point_v_out;
  logic [15:0]   endpoint_count, branch_count;
  logic          frame_done, overflow;

  skeleton_feature_extractor #(
    .HORIZONTAL_COUNT (H),
    .VERTICAL_COUNT   (V),
    .FIFO_DEPTH       (D)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .pixel_in        (pixel_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .pixel_valid_in  (pixel_valid_in),
    .point_valid_out (point_valid_out),
    .point_ready_in  (point_ready_in),
    .point_type_out  (point_type_out),
    .point_h_out     (point_h_out),
    .point_v_out     (point_v_out),
    .endpoint_count  (endpoint_count),
    .branch_count    (branch_count),
    .frame_done      (frame_done),
    .overflow        (overflow)
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_done   = 0;
  int          trig_cyc = -1;
  int          first_pop_cyc = -1;
  logic [6:0]  exp_q [$];
  logic [31:0] cnt_q [$];
  logic [7:0]  img [V];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] rec(input logic t, input int h, input int v);
    return {t, 3'(h), 3'(v)};
  endfunction

  // Monitor: compare every accepted record and every published count pair.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (point_valid_out && point_ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", {25'd0, point_type_out, point_h_out, point_v_out}, 32'hFFFF_FFFF);
        end else begin
          check("record", {25'd0, point_type_out, point_h_out, point_v_out}, {25'd0, exp_q.pop_front()});
          if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
      end
      if (frame_done) begin
        n_done++;
        if (cnt_q.size() == 0)
          check("unexpected_frame_done", {endpoint_count, branch_count}, 32'hFFFF_FFFF);
        else
          check("counts", {endpoint_count, branch_count}, cnt_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_img();
    for (int v = 0; v < V; v++) img[v] = 8'h00;
  endtask

  // gap != 0 inserts an idle cycle after every third pixel.
  task automatic send_frame(input int gap);
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        pixel_valid_in = 1'b1;
        hcount_in      = 3'(h);
        vcount_in      = 3'(v);
        pixel_in       = img[v][h];
        if (h == 2 && v == 3) trig_cyc = cyc;
        tick();
        if (gap != 0 && ((v * H + h) % 3 == 2)) begin
          pixel_valid_in = 1'b0;
          tick();
        end
      end
    end
    pixel_valid_in = 1'b0;
    pixel_in       = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || cnt_q.size() != 0); i++) tick();
    check(name, exp_q.size() + cnt_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_valid",    point_valid_out, 0);
    check("rst_counts",   {endpoint_count, branch_count}, 0);
    check("rst_done_ovf", {frame_done, overflow}, 0);
    check("rst_fields",   {point_type_out, point_h_out, point_v_out}, 0);
    tick();
    rst_n_in = 1'b1;
    tick();
    point_ready_in = 1'b1;

    // 1: horizontal line, contiguous pixels
    clear_img();
    img[2] = 8'b0111_1110;
    exp_q.push_back(rec(0, 1, 2));
    exp_q.push_back(rec(0, 6, 2));
    cnt_q.push_back({16'd2, 16'd0});
    send_frame(0);
    drain("t1_drain");
    check("t1_latency", first_pop_cyc - trig_cyc, 2);

    // 2: plus shape centred (3,3), input gaps
    clear_img();
    img[1] = 8'b0000_1000;
    img[2] = 8'b0000_1000;
    img[3] = 8'b0011_1110;
    img[4] = 8'b0000_1000;
    img[5] = 8'b0000_1000;
    exp_q.push_back(rec(0, 3, 1));
    exp_q.push_back(rec(0, 1, 3));
    exp_q.push_back(rec(1, 3, 3));
    exp_q.push_back(rec(0, 5, 3));
    exp_q.push_back(rec(0, 3, 5));
    cnt_q.push_back({16'd4, 16'd1});
    send_frame(1);
    drain("t2_drain");

    // 3: isolated pixel plus full border ring
    for (int v = 0; v < V; v++) img[v] = 8'b1000_0001;
    img[0] = 8'hFF;
    img[V-1] = 8'hFF;
    img[2] = 8'b1001_0001;
    cnt_q.push_back({16'd0, 16'd0});
    send_frame(0);
    drain("t3_drain");
    check("t3_overflow", overflow, 0);

    // 4: consumer stalled, six endpoints into a 4-deep FIFO
    point_ready_in = 1'b0;
    clear_img();
    img[1] = 8'b0000_0110;
    img[3] = 8'b0000_0110;
    img[5] = 8'b0000_0110;
    exp_q.push_back(rec(0, 1, 1));
    exp_q.push_back(rec(0, 2, 1));
    exp_q.push_back(rec(0, 1, 3));
    exp_q.push_back(rec(0, 2, 3));
    cnt_q.push_back({16'd6, 16'd0});
    send_frame(0);
    for (int i = 0; i < 4; i++) tick();
    check("t4_overflow", overflow, 1);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_valid", point_valid_out, 1);
      check("t4_hold_head", {point_type_out, point_h_out, point_v_out}, rec(0, 1, 1));
      tick();
    end
    point_ready_in = 1'b1;
    drain("t4_drain");
    check("t4_overflow_kept", overflow, 1);

    // 5: FIFO full, ready toggling, pushes aligned with pops
    clear_img();
    img[1] = 8'b0011_0110;
    img[3] = 8'b0011_0110;
    img[5] = 8'b0011_0110;
    for (int r = 1; r < 6; r += 2) begin
      exp_q.push_back(rec(0, 1, r));
      exp_q.push_back(rec(0, 2, r));
      exp_q.push_back(rec(0, 4, r));
      exp_q.push_back(rec(0, 5, r));
    end
    cnt_q.push_back({16'd12, 16'd0});
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        pixel_valid_in = 1'b1;
        hcount_in      = 3'(h);
        vcount_in      = 3'(v);
        pixel_in       = img[v][h];
        point_ready_in = 1'b0;
        tick();
        if (v == 0 && h == 0) check("t5_overflow_cleared", overflow, 0);
        pixel_valid_in = 1'b0;
        point_ready_in = ((v == 4 && h >= 2) || v > 4);
        tick();
      end
    end
    point_ready_in = 1'b1;
    drain("t5_drain");
    check("t5_no_drop", overflow, 0);

    // 6: reset mid-frame, then a clean repeat of the horizontal line frame
    clear_img();
    img[2] = 8'b0111_1110;
    for (int i = 0; i < 2 * H + 5; i++) begin
      pixel_valid_in = 1'b1;
      hcount_in      = 3'(i % H);
      vcount_in      = 3'(i / H);
      pixel_in       = img[i / H][i % H];
      tick();
    end
    pixel_valid_in = 1'b0;
    rst_n_in = 1'b0;
    #2;
    check("t6_rst_valid",  point_valid_out, 0);
    check("t6_rst_counts", {endpoint_count, branch_count}, 0);
    check("t6_rst_flags",  {frame_done, overflow}, 0);
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
    exp_q.push_back(rec(0, 1, 2));
    exp_q.push_back(rec(0, 6, 2));
    cnt_q.push_back({16'd2, 16'd0});
    send_frame(0);
    drain("t6_drain");

    check("frame_done_pulses", n_done, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
